// File: rtl/ddr_a2m_beat_addr_gen.sv
// AXI AW/AR command to per-beat MBA address sequencer.
// Accepts one command, then presents len+1 beats carrying address, index,
// LAST and an error flag. The wrap window is confined to ADDR[7:0].
module ddr_a2m_beat_addr_gen #(
  parameter int ADDR_W   = 32,
  parameter int ID_W     = 4,
  parameter int MAX_SIZE = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [ID_W-1:0]   CMD_ID,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [7:0]        CMD_LEN,
  input  logic [2:0]        CMD_SIZE,
  input  logic [1:0]        CMD_BURST,
  output logic              BEAT_VALID,
  input  logic              BEAT_READY,
  output logic [ID_W-1:0]   BEAT_ID,
  output logic [ADDR_W-1:0] BEAT_ADDR,
  output logic [2:0]        BEAT_SIZE,
  output logic [7:0]        BEAT_CNT,
  output logic              BEAT_LAST,
  output logic              BEAT_ERR,
  output logic              BUSY
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [1:0] B_FIXED = 2'b00;
  localparam logic [1:0] B_INCR  = 2'b01;
  localparam logic [1:0] B_WRAP  = 2'b10;
  localparam logic [1:0] B_RSVD  = 2'b11;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              beat_valid, beat_last, beat_acc, cmd_acc;
  logic [ADDR_W-1:0] cmd_step_mask;
  logic              wrap_len_ok, cmd_err;
  logic [ADDR_W-1:0] step, incr_addr, wrap_addr, next_addr;
  logic [8:0]        wrap_span;
  logic [7:0]        wm, lo_sum;

  assign beat_valid = (state_q == RUN);
  assign beat_last  = beat_valid & (cnt_q == len_q);
  assign beat_acc   = beat_valid & BEAT_READY;
  // New command may enter while idle or in the cycle the final beat leaves,
  // which gives back-to-back bursts; held off entirely while in reset.
  assign CMD_READY  = RST_N & ((state_q == IDLE) | (beat_acc & beat_last));
  assign cmd_acc    = CMD_VALID & CMD_READY;

  // Classify the incoming command as illegal
  always_comb begin
    cmd_step_mask = (ADDR_W'(1) << CMD_SIZE) - ADDR_W'(1);
    wrap_len_ok   = (CMD_LEN == 8'd1) | (CMD_LEN == 8'd3) |
                    (CMD_LEN == 8'd7) | (CMD_LEN == 8'd15);
    cmd_err       = (CMD_BURST == B_RSVD) | (CMD_SIZE > 3'(MAX_SIZE)) |
                    ((CMD_BURST == B_WRAP) &
                     (~wrap_len_ok | (|(CMD_ADDR & cmd_step_mask))));
  end

  // Next beat address for the registered burst type
  always_comb begin
    step      = ADDR_W'(1) << size_q;
    incr_addr = (addr_q & ~(step - ADDR_W'(1))) + step;
    wrap_span = (9'(len_q) + 9'd1) << size_q;
    wm        = 8'(wrap_span - 9'd1);
    lo_sum    = addr_q[7:0] + step[7:0];
    wrap_addr = addr_q;
    wrap_addr[7:0] = (addr_q[7:0] & ~wm) | (lo_sum & wm);
    unique case (burst_q)
      B_FIXED: next_addr = addr_q;
      B_WRAP:  next_addr = wrap_addr;
      default: next_addr = incr_addr;
    endcase
  end

  // Load a burst on command accept, advance it on beat accept
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (cmd_acc) begin
      state_d = RUN;
      id_d    = CMD_ID;
      addr_d  = CMD_ADDR;
      len_d   = CMD_LEN;
      size_d  = CMD_SIZE;
      // Illegal bursts still emit every beat, sequenced as INCR
      burst_d = cmd_err ? B_INCR : CMD_BURST;
      err_d   = cmd_err;
      cnt_d   = 8'd0;
    end else if (beat_acc) begin
      if (beat_last) begin
        state_d = IDLE;
      end else begin
        addr_d = next_addr;
        cnt_d  = cnt_q + 8'd1;
      end
    end
  end

  // Burst state registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= B_FIXED;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BEAT_VALID = beat_valid;
  assign BEAT_ID    = id_q;
  assign BEAT_ADDR  = addr_q;
  assign BEAT_SIZE  = size_q;
  assign BEAT_CNT   = cnt_q;
  assign BEAT_LAST  = beat_last;
  assign BEAT_ERR   = err_q;
  assign BUSY       = beat_valid;

endmodule
